// File: rtl/apb_mem_bridge.sv
// rtl/apb_mem_bridge.sv - APB slave bridging single transfers onto a req/ack memory port
module apb_mem_bridge #(
    parameter int SIZE       = 8,
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = $clog2(SIZE),
    parameter int APB_ADDR_W = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [APB_ADDR_W-1:0] paddr,
    input  logic [WIDTH_DATA-1:0] pwdata,
    output logic [WIDTH_DATA-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic                  mem_req,
    output logic                  mem_op,
    output logic [WIDTH_ADDR-1:0] mem_addr,
    output logic [WIDTH_DATA-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_hit,
    input  logic [WIDTH_DATA-1:0] mem_rdata,
    output logic [7:0]            err_count
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [APB_ADDR_W:0]   SIZE_EXT = (APB_ADDR_W + 1)'(SIZE);

    typedef enum logic [1:0] {
        ST_WAIT         = 2'b00,
        ST_REQ_RECEIVED = 2'b01,
        ST_REQ_DONE     = 2'b10
    } state_t;

    state_t                state_q, state_d;
    logic                  op_q, op_d;
    logic [WIDTH_ADDR-1:0] addr_q, addr_d;
    logic [WIDTH_DATA-1:0] wdata_q, wdata_d;
    logic [WIDTH_DATA-1:0] rdata_q, rdata_d;
    logic                  error_q, error_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            err_count_q, err_count_d;

    logic completion;
    logic in_range;

    assign in_range   = ({1'b0, paddr} < SIZE_EXT);
    assign completion = (state_q == ST_REQ_DONE) && psel && penable;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        error_d     = error_q;
        tmo_d       = tmo_q;
        err_count_d = err_count_q;

        case (state_q)
            ST_WAIT: begin
                if (psel && !penable) begin
                    op_d    = pwrite;
                    addr_d  = paddr[WIDTH_ADDR-1:0];
                    wdata_d = pwdata;
                    rdata_d = '0;
                    tmo_d   = '0;
                    // Out-of-range requests never reach the memory side.
                    error_d = !in_range;
                    state_d = in_range ? ST_REQ_RECEIVED : ST_REQ_DONE;
                end
            end
            ST_REQ_RECEIVED: begin
                // An ack landing on the last allowed cycle wins over the timeout.
                if (mem_ack) begin
                    if (!op_q) begin
                        rdata_d = mem_rdata;
                    end
                    error_d = !op_q && !mem_hit;
                    state_d = ST_REQ_DONE;
                end else if (tmo_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_REQ_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_REQ_DONE: begin
                if (!psel || penable) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        if (completion && error_q && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            op_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            error_q     <= 1'b0;
            tmo_q       <= '0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            error_q     <= error_d;
            tmo_q       <= tmo_d;
            err_count_q <= err_count_d;
        end
    end

    assign pready    = completion;
    assign pslverr   = completion && error_q;
    assign prdata    = (completion && !error_q && !op_q) ? rdata_q : '0;
    assign mem_req   = (state_q == ST_REQ_RECEIVED);
    assign mem_op    = op_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// tb/tb_apb_mem_bridge.sv - directed self-checking bench for apb_mem_bridge
module tb_apb_mem_bridge;

    logic       clk;
    logic       rst;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic [7:0] prdata;
    logic       pready, pslverr;
    logic       mem_req, mem_op;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack, mem_hit;
    logic [7:0] mem_rdata;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    apb_mem_bridge dut (
        .clk(clk), .rst(rst),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_hit(mem_hit), .mem_rdata(mem_rdata),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Results of the last transfer driven by run_xfer.
    int         req_cycles, ready_at;
    logic       r_slverr, r_op, r_ready_after;
    logic [7:0] r_rd, r_wd;
    logic [2:0] r_addr;

    // Drives one APB transfer starting at cycle 0 (setup); mem_ack pulses at cycle ack_at (0 = never).
    task automatic run_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                            input int ack_at, input logic hit, input logic [7:0] rd_in);
        int c;
        bit done;
        c = 0; done = 0;
        req_cycles = 0; ready_at = -1; r_slverr = 0; r_rd = 0;
        r_op = 0; r_addr = 0; r_wd = 0; r_ready_after = 0;
        psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = wd;
        mem_hit = hit; mem_rdata = rd_in;
        while (!done && c < 40) begin
            if (c > 0) penable = 1;
            mem_ack = (ack_at > 0) && (c == ack_at);
            @(negedge clk);
            if (mem_req) begin
                if (req_cycles == 0) begin
                    r_op = mem_op; r_addr = mem_addr; r_wd = mem_wdata;
                end
                req_cycles++;
            end
            if (pready) begin
                ready_at = c; r_slverr = pslverr; r_rd = prdata; done = 1;
            end
            @(posedge clk); #1;
            c++;
        end
        psel = 0; penable = 0; mem_ack = 0;
        @(negedge clk);
        r_ready_after = pready;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1; psel = 1; penable = 0; pwrite = 1; paddr = 8'd2; pwdata = 8'hFF;
        mem_ack = 1; mem_hit = 1; mem_rdata = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        psel = 0; mem_ack = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        checks++; if ({mem_op, mem_addr, mem_wdata} !== 12'h000) begin errors++; $display("FAIL reset_mem_bus got %h exp 000", {mem_op, mem_addr, mem_wdata}); end
        checks++; if ({pready, pslverr, prdata} !== 10'h000) begin errors++; $display("FAIL reset_apb got %h exp 000", {pready, pslverr, prdata}); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        run_xfer(1'b1, 8'd3, 8'hA5, 2, 1'b0, 8'h00);
        checks++; if (req_cycles !== 2) begin errors++; $display("FAIL wr_req_cycles got %0d exp 2", req_cycles); end
        checks++; if ({r_op, r_addr, r_wd} !== {1'b1, 3'd3, 8'hA5}) begin errors++; $display("FAIL wr_mem_bus got %h exp %h", {r_op, r_addr, r_wd}, {1'b1, 3'd3, 8'hA5}); end
        checks++; if (ready_at !== 3) begin errors++; $display("FAIL wr_ready_cycle got %0d exp 3", ready_at); end
        checks++; if ({r_slverr, r_rd} !== 9'h000) begin errors++; $display("FAIL wr_resp got %h exp 000", {r_slverr, r_rd}); end
        checks++; if (r_ready_after !== 1'b0) begin errors++; $display("FAIL wr_ready_one_cycle got %b exp 0", r_ready_after); end
    endtask

    task automatic test_read_hit();
        run_xfer(1'b0, 8'd5, 8'h00, 3, 1'b1, 8'h3C);
        checks++; if ({r_op, r_addr} !== {1'b0, 3'd5}) begin errors++; $display("FAIL rd_mem_bus got %h exp %h", {r_op, r_addr}, {1'b0, 3'd5}); end
        checks++; if (ready_at !== 4) begin errors++; $display("FAIL rd_ready_cycle got %0d exp 4", ready_at); end
        checks++; if ({r_slverr, r_rd} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL rd_resp got %h exp 03c", {r_slverr, r_rd}); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rd_err_count got %0d exp 0", err_count); end
    endtask

    task automatic test_errors();
        run_xfer(1'b0, 8'd2, 8'h00, 1, 1'b0, 8'hEE);
        checks++; if ({r_slverr, r_rd} !== {1'b1, 8'h00}) begin errors++; $display("FAIL miss_resp got %h exp 100", {r_slverr, r_rd}); end
        checks++; if (ready_at !== 2) begin errors++; $display("FAIL miss_ready_cycle got %0d exp 2", ready_at); end
        run_xfer(1'b0, 8'd8, 8'h00, 1, 1'b1, 8'h11);
        checks++; if (req_cycles !== 0) begin errors++; $display("FAIL oor_req_cycles got %0d exp 0", req_cycles); end
        checks++; if (ready_at !== 1) begin errors++; $display("FAIL oor_ready_cycle got %0d exp 1", ready_at); end
        checks++; if (r_slverr !== 1'b1) begin errors++; $display("FAIL oor_slverr got %b exp 1", r_slverr); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL err_count_two got %0d exp 2", err_count); end
    endtask

    task automatic test_timeout();
        run_xfer(1'b0, 8'd6, 8'h00, 0, 1'b1, 8'h00);
        checks++; if (req_cycles !== 16) begin errors++; $display("FAIL tmo_req_cycles got %0d exp 16", req_cycles); end
        checks++; if ({ready_at == 17, r_slverr} !== 2'b11) begin errors++; $display("FAIL tmo_resp ready_at %0d slverr %b exp 17 1", ready_at, r_slverr); end
        run_xfer(1'b0, 8'd7, 8'h00, 16, 1'b1, 8'h5A);
        checks++; if (req_cycles !== 16) begin errors++; $display("FAIL ack16_req_cycles got %0d exp 16", req_cycles); end
        checks++; if ({r_slverr, r_rd} !== {1'b0, 8'h5A}) begin errors++; $display("FAIL ack16_resp got %h exp 05a", {r_slverr, r_rd}); end
        checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL tmo_err_count got %0d exp 3", err_count); end
    endtask

    task automatic test_abort();
        bit seen;
        seen = 0;
        psel = 1; penable = 0; pwrite = 0; paddr = 8'd200; pwdata = 8'h00;
        @(posedge clk); #1;
        psel = 0;
        repeat (3) begin
            @(negedge clk);
            if (pready) seen = 1;
            @(posedge clk); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_pready got %b exp 0", seen); end
        checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL abort_err_count got %0d exp 3", err_count); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        seen = 0;
        psel = 1; penable = 0; pwrite = 0; paddr = 8'd4; pwdata = 8'h00; mem_ack = 0;
        @(posedge clk); #1;
        penable = 1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mrst_req_before got %b exp 1", mem_req); end
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; psel = 0; penable = 0;
        @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mrst_req_after got %b exp 0", mem_req); end
        repeat (3) begin
            if (pready) seen = 1;
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mrst_pready got %b exp 0", seen); end
        run_xfer(1'b0, 8'd1, 8'h00, 2, 1'b1, 8'h77);
        checks++; if ({ready_at == 3, r_slverr, r_rd} !== {2'b10, 8'h77}) begin errors++; $display("FAIL mrst_read ready_at %0d slverr %b rd %h exp 3 0 77", ready_at, r_slverr, r_rd); end
    endtask

    task automatic test_spurious_ack();
        bit toggled;
        toggled = 0;
        psel = 0; penable = 0; mem_hit = 0; mem_rdata = 8'hC3;
        repeat (3) begin
            mem_ack = 1;
            @(negedge clk);
            if (mem_req || pready || pslverr || (prdata != 8'h00) || (mem_op != 1'b0) ||
                (mem_addr != 3'd1) || (mem_wdata != 8'h00) || (err_count != 8'd0)) toggled = 1;
            @(posedge clk); #1;
            mem_ack = 0;
        end
        checks++; if (toggled !== 1'b0) begin errors++; $display("FAIL spurious_ack outputs moved got %b exp 0", toggled); end
        run_xfer(1'b1, 8'd0, 8'h42, 1, 1'b0, 8'h00);
        checks++; if ({ready_at == 2, r_slverr, r_wd} !== {2'b10, 8'h42}) begin errors++; $display("FAIL post_spurious ready_at %0d slverr %b wd %h exp 2 0 42", ready_at, r_slverr, r_wd); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 255; i++) run_xfer(1'b1, 8'd9, 8'h00, 0, 1'b0, 8'h00);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_reach got %0d exp 255", err_count); end
        for (int i = 0; i < 2; i++) run_xfer(1'b1, 8'd9, 8'h00, 0, 1'b0, 8'h00);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", err_count); end
        checks++; if (r_slverr !== 1'b1) begin errors++; $display("FAIL sat_slverr got %b exp 1", r_slverr); end
    endtask

    initial begin
        rst = 1; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        mem_ack = 0; mem_hit = 0; mem_rdata = 0;
        test_reset();
        test_write();
        test_read_hit();
        test_errors();
        test_timeout();
        test_abort();
        test_mid_reset();
        test_spurious_ack();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_mem_bridge.md
APB_MEM_BRIDGE -- requirements
Module: apb_mem_bridge

Interface
REQ-001 Parameter SIZE, default 8, number of memory locations served.
REQ-002 Parameter WIDTH_DATA, default 8, data width.
REQ-003 Parameter WIDTH_ADDR, default $clog2(SIZE), memory-side address width.
REQ-004 Parameter APB_ADDR_W, default 8, APB address width.
REQ-005 Parameter TIMEOUT, default 16, max cycles waiting for mem_ack.
REQ-006 The port list SHALL be as follows; the block has one clock, and reset is synchronous and active-high:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  APB_ADDR_W  APB address.
- pwdata  in  WIDTH_DATA  APB write data.
- prdata  out  WIDTH_DATA  APB read data.
- pready  out  1  APB transfer complete.
- pslverr  out  1  APB error, valid with pready.
- mem_req  out  1  request to downstream memory/search engine.
- mem_op  out  1  0=mem_read, 1=mem_write.
- mem_addr  out  WIDTH_ADDR  memory address.
- mem_wdata  out  WIDTH_DATA  memory write data.
- mem_ack  in  1  downstream completion, one-cycle pulse.
- mem_hit  in  1  read found, valid with mem_ack.
- mem_rdata  in  WIDTH_DATA  read data, valid with mem_ack.
- err_count  out  8  saturating count of pslverr responses.

Function
REQ-007 FSM states SHALL be WAIT, REQ_RECEIVED and REQ_DONE, with WAIT as the reset state; any unused encoding SHALL return to WAIT on the next edge.
REQ-008 In WAIT, a cycle with psel=1 and penable=0 (setup phase) SHALL capture pwrite, paddr and pwdata.
- If paddr < SIZE, the FSM SHALL go to REQ_RECEIVED.
- Otherwise the FSM SHALL go to REQ_DONE with the error flag set, and no mem_req SHALL be issued.
REQ-009 In REQ_RECEIVED, the request outputs SHALL behave as follows:
- mem_req=1, held until mem_ack is sampled.
- mem_op, mem_addr and mem_wdata SHALL stay stable from the captured values; mem_addr is paddr[WIDTH_ADDR-1:0].
REQ-010 On mem_ack=1 in REQ_RECEIVED, the block SHALL:
- latch mem_rdata for reads;
- set error = (read AND NOT mem_hit);
- go to REQ_DONE, with mem_req=0 from the next cycle.
REQ-011 The timeout counter SHALL behave as follows:
- clears on entry to REQ_RECEIVED;
- increments each REQ_RECEIVED cycle without mem_ack;
- on reaching TIMEOUT-1 without mem_ack, drops mem_req, sets error and goes to REQ_DONE.
REQ-012 If mem_ack arrives in the same cycle the timeout expires, mem_ack SHALL take priority and no timeout error SHALL be flagged.
REQ-013 In REQ_DONE with psel=1 and penable=1, the block SHALL:
- drive pready=1 (combinational from state) for exactly one cycle;
- drive pslverr = error flag;
- drive prdata = latched data for a successful read, else 0;
- return to WAIT on that edge.
REQ-014 In REQ_DONE with psel=0 (master abort), the FSM SHALL return to WAIT without asserting pready.
REQ-015 pready, pslverr and prdata SHALL be 0 in all cycles other than the REQ_DONE completion cycle.
REQ-016 mem_ack in WAIT or REQ_DONE SHALL be ignored.
REQ-017 err_count SHALL increment on each completion cycle with pslverr=1 and saturate at 255.
REQ-018 Latency: setup at cycle 0, mem_req=1 at cycle 1, mem_ack at cycle k, pready=1 at cycle k+1 (given penable=1).
REQ-019 An out-of-range address SHALL complete with pready at cycle 1 after setup.

Reset
REQ-020 While rst=1 at a rising edge, the block SHALL set FSM=WAIT, mem_req=0, mem_op=0, mem_addr=0, mem_wdata=0, pready=0, pslverr=0, prdata=0, err_count=0, error flag=0 and timeout counter=0.
REQ-021 A reset asserted mid-transaction SHALL discard the pending transfer: mem_req=0 after that edge and no pready is issued for the aborted transfer.

Verification
REQ-022 Write: paddr=3, pwdata=8'hA5, ack after 2 cycles -> mem_req high 2 cycles with mem_op=1, mem_addr=3, mem_wdata=A5; then pready=1, pslverr=0, prdata=0.
REQ-023 Read hit: paddr=5, mem_ack with mem_hit=1 and mem_rdata=8'h3C -> prdata=3C, pslverr=0, err_count unchanged.
REQ-024 Read miss and out-of-range:
- mem_hit=0 -> pslverr=1.
- paddr=8 -> pready at cycle 1 after setup, pslverr=1, no mem_req.
- err_count=2 after both.
REQ-025 Timeout: mem_ack never arrives -> mem_req drops after 16 cycles, then pready=1 with pslverr=1; a separate case with mem_ack on the 16th cycle -> pslverr=0.
REQ-026 rst=1 during REQ_RECEIVED -> mem_req=0 next cycle and no pready; a subsequent read of paddr=1 completes normally.
REQ-027 Spurious mem_ack in WAIT -> no state change and no outputs toggle; err_count driven past 255 -> holds 255.
